// File: rtl/state_mon.sv
// Observer for the IDLE->S1->S2 enable sequencer: measures S1/S2 phase lengths,
// counts completed rounds and latches the first illegal code or transition.
module state_mon #(
    parameter int DUR_W = 16,
    parameter int RND_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       state_in,
    input  logic             err_clr,
    output logic [DUR_W-1:0] dur_s1,
    output logic [DUR_W-1:0] dur_s2,
    output logic             dur_vld,
    output logic [RND_W-1:0] round_cnt,
    output logic             err,
    output logic [3:0]       err_info
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S1   = 2'b01,
        S2   = 2'b10,
        BAD  = 2'b11
    } st_t;

    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    st_t              r_st;
    logic [DUR_W-1:0] r_run_cnt;
    logic [DUR_W-1:0] r_s1_cap;
    logic             r_round_ok;

    st_t              w_st_in;
    logic             w_trans;
    logic             w_legal;
    logic             w_err;
    logic             w_start;
    logic             w_cap;
    logic             w_done;
    logic [DUR_W-1:0] w_run_nxt;

    always_comb begin
        w_st_in   = st_t'(state_in);
        w_trans   = (w_st_in != r_st);
        w_legal   = 1'b0;
        w_start   = 1'b0;
        w_cap     = 1'b0;
        w_done    = 1'b0;
        case (r_st)
            IDLE: w_legal = (w_st_in == S1);
            S1:   w_legal = (w_st_in == S2);
            S2:   w_legal = (w_st_in == IDLE);
            default: w_legal = 1'b0;
        endcase
        // A held 2'b11 is an error on every cycle it persists.
        w_err = (w_trans && !w_legal) || (!w_trans && r_st == BAD);
        if (w_trans && w_legal) begin
            w_start = (r_st == IDLE);
            w_cap   = (r_st == S1);
            w_done  = (r_st == S2) && r_round_ok;
        end
        if (w_trans)
            w_run_nxt = DUR_W'(1);
        else if (r_run_cnt == DUR_MAX)
            w_run_nxt = r_run_cnt;
        else
            w_run_nxt = r_run_cnt + DUR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st       <= IDLE;
            r_run_cnt  <= '0;
            r_s1_cap   <= '0;
            r_round_ok <= 1'b0;
        end else begin
            r_st      <= w_st_in;
            r_run_cnt <= w_run_nxt;
            if (w_cap)
                r_s1_cap <= r_run_cnt;
            if (w_err || w_done)
                r_round_ok <= 1'b0;
            else if (w_start)
                r_round_ok <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_s1    <= '0;
            dur_s2    <= '0;
            dur_vld   <= 1'b0;
            round_cnt <= '0;
        end else begin
            dur_vld <= w_done;
            if (w_done) begin
                dur_s1    <= r_s1_cap;
                dur_s2    <= r_run_cnt;
                round_cnt <= round_cnt + RND_W'(1);
            end
        end
    end

    // A new error beats a coincident clear and re-arms the capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_info <= '0;
        end else if (w_err) begin
            err <= 1'b1;
            if (!err || err_clr)
                err_info <= {r_st, state_in};
        end else if (err_clr) begin
            err      <= 1'b0;
            err_info <= '0;
        end
    end

endmodule

// File: tb/tb_state_mon.sv
// Randomised and directed bench for state_mon: a wide and a narrow instance share
// stimulus and are compared every cycle against an unbounded-integer model.
module tb_state_mon;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_in = 2'b00;
    logic       err_clr = 1'b0;

    logic [15:0] w_s1, w_s2;
    logic        w_vld, w_err;
    logic [7:0]  w_rnd;
    logic [3:0]  w_info;
    logic [3:0]  n_s1, n_s2;
    logic        n_vld, n_err;
    logic [1:0]  n_rnd;
    logic [3:0]  n_info;

    int n_chk = 0;
    int n_pass = 0;

    state_mon #(.DUR_W(16), .RND_W(8)) u_wide (
        .clk(clk), .rst_n(rst_n), .state_in(state_in), .err_clr(err_clr),
        .dur_s1(w_s1), .dur_s2(w_s2), .dur_vld(w_vld), .round_cnt(w_rnd),
        .err(w_err), .err_info(w_info)
    );

    state_mon #(.DUR_W(4), .RND_W(2)) u_narrow (
        .clk(clk), .rst_n(rst_n), .state_in(state_in), .err_clr(err_clr),
        .dur_s1(n_s1), .dur_s2(n_s2), .dur_vld(n_vld), .round_cnt(n_rnd),
        .err(n_err), .err_info(n_info)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model: phase lengths as plain unbounded integers; widths applied only at compare.
    int        m_prev = 0, m_len = 0, m_s1len = 0, m_ds1 = 0, m_ds2 = 0, m_rounds = 0;
    bit        m_inr = 0, m_vld = 0, m_err = 0;
    int        m_info = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 0; m_len = 0; m_s1len = 0; m_ds1 = 0; m_ds2 = 0;
            m_rounds = 0; m_inr = 0; m_vld = 0; m_err = 0; m_info = 0;
        end else begin
            int  s;
            bit  legal, bad;
            s = int'(state_in);
            legal = (m_prev == 0 && s == 1) || (m_prev == 1 && s == 2) || (m_prev == 2 && s == 0);
            bad = (s != m_prev && !legal) || (s == 3 && m_prev == 3);
            m_vld = 0;
            if (bad) begin
                m_inr = 0;
                if (!m_err || err_clr) m_info = m_prev * 4 + s;
                m_err = 1;
            end else begin
                if (err_clr) begin m_err = 0; m_info = 0; end
                if (m_prev == 0 && s == 1) m_inr = 1;
                if (m_prev == 1 && s == 2) m_s1len = m_len;
                if (m_prev == 2 && s == 0 && m_inr) begin
                    m_ds1 = m_s1len; m_ds2 = m_len; m_rounds++; m_vld = 1; m_inr = 0;
                end
            end
            m_len = (s != m_prev) ? 1 : m_len + 1;
            m_prev = s;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("w_vld",  w_vld,  m_vld);
            chk("w_s1",   w_s1,   sat(m_ds1, 16));
            chk("w_s2",   w_s2,   sat(m_ds2, 16));
            chk("w_rnd",  w_rnd,  m_rounds % 256);
            chk("w_err",  w_err,  m_err);
            chk("w_info", w_info, m_info);
            chk("n_vld",  n_vld,  m_vld);
            chk("n_s1",   n_s1,   sat(m_ds1, 4));
            chk("n_s2",   n_s2,   sat(m_ds2, 4));
            chk("n_rnd",  n_rnd,  m_rounds % 4);
            chk("n_err",  n_err,  m_err);
            chk("n_info", n_info, m_info);
        end
    end

    task automatic hold(input logic [1:0] s, input int n);
        repeat (n) begin
            @(negedge clk);
            state_in = s;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        tick();
        chk("clr_err", w_err, 0);
        chk("clr_info", w_info, 0);
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_s1"}, w_s1, 0);    chk({nm, "_s2"}, w_s2, 0);
        chk({nm, "_vld"}, w_vld, 0);  chk({nm, "_rnd"}, w_rnd, 0);
        chk({nm, "_err"}, w_err, 0);  chk({nm, "_info"}, w_info, 0);
        chk({nm, "_nrnd"}, n_rnd, 0); chk({nm, "_ns1"}, n_s1, 0);
    endtask

    initial begin
        int wrap_exp [5];
        wrap_exp[0] = 1; wrap_exp[1] = 2; wrap_exp[2] = 3; wrap_exp[3] = 0; wrap_exp[4] = 1;

        #1;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal round
        hold(0, 3); hold(1, 10); hold(2, 14); hold(0, 1); tick();
        chk("nom_vld", w_vld, 1); chk("nom_s1", w_s1, 10); chk("nom_s2", w_s2, 14);
        chk("nom_rnd", w_rnd, 1); chk("nom_err", w_err, 0);
        tick();
        chk("nom_vld_pulse", w_vld, 0);

        // Back-to-back rounds
        hold(1, 1); hold(2, 1); hold(0, 1); tick();
        chk("b2b1_s1", w_s1, 1); chk("b2b1_s2", w_s2, 1);
        hold(1, 5); hold(2, 7); hold(0, 1); tick();
        chk("b2b2_s1", w_s1, 5); chk("b2b2_s2", w_s2, 7);
        hold(1, 2); hold(2, 300); hold(0, 1); tick();
        chk("b2b3_s2", w_s2, 300); chk("b2b3_ns2", n_s2, 15); chk("b2b3_rnd", w_rnd, 4);

        // Narrow-counter saturation
        hold(1, 20); hold(2, 3); hold(0, 1); tick();
        chk("sat_vld", n_vld, 1); chk("sat_ns1", n_s1, 15); chk("sat_ns2", n_s2, 3);
        chk("sat_ws1", w_s1, 20); chk("sat_rnd", w_rnd, 5);

        // S1->IDLE aborts the first round; the second still reports
        hold(0, 2); hold(1, 4); hold(0, 1); hold(1, 2); hold(2, 2); hold(0, 1); tick();
        chk("ill_vld", w_vld, 1); chk("ill_s1", w_s1, 2); chk("ill_s2", w_s2, 2);
        chk("ill_err", w_err, 1); chk("ill_info", w_info, 4'b0100); chk("ill_rnd", w_rnd, 6);
        pulse_clr();

        // Illegal code held, then clear on a clean cycle
        hold(3, 2); hold(0, 1); tick();
        chk("bad_err", w_err, 1); chk("bad_info", w_info, 4'b0011);
        pulse_clr();

        // Clear coincident with S2->S1: set wins and info is re-captured
        hold(3, 1); hold(0, 1); hold(1, 2); hold(2, 2);
        @(negedge clk);
        state_in = 2'b01; err_clr = 1'b1;
        tick();
        chk("coin_err", w_err, 1); chk("coin_info", w_info, 4'b1001);
        @(negedge clk);
        err_clr = 1'b0; state_in = 2'b10;
        hold(0, 1); tick();
        chk("coin_novld", w_vld, 0);
        pulse_clr();

        // Randomised sequencing with occasional illegal codes and clears
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 30)      state_in = (state_in == 2'b00) ? 2'b01 : (state_in == 2'b01) ? 2'b10 : 2'b00;
            else if (r < 33) state_in = 2'($urandom_range(0, 3));
            err_clr = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        err_clr = 1'b0;

        // Reset mid-round discards the partial round
        hold(0, 1); hold(1, 3); hold(2, 2);
        @(negedge clk);
        rst_n = 1'b0; state_in = 2'b00;
        #1;
        chk_zero("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(0, 3); tick();
        chk("post_rst_vld", w_vld, 0); chk("post_rst_rnd", w_rnd, 0);

        // Narrow round counter wraps
        for (int i = 0; i < 5; i++) begin
            hold(1, 1); hold(2, 1); hold(0, 1); tick();
            chk("wrap_nrnd", n_rnd, wrap_exp[i]);
            chk("wrap_wrnd", w_rnd, i + 1);
        end

        hold(0, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/state_mon.md
Name: state_mon

Overview:
- Downstream observer for the three-state enable sequencer (IDLE=2'b00, S1=2'b01, S2=2'b10).
- Consumes the sequencer's 2-bit state code and measures how many clock cycles each S1 and S2 phase lasts.
- Counts completed IDLE->S1->S2->IDLE rounds and flags illegal codes or illegal transitions.
- Results feed LED/segment display logic and the debug register bank.

Parameters:
- DUR_W, 16: width of the phase-duration counters and outputs. Counters saturate at 2^DUR_W-1.
- RND_W, 8: width of the completed-round counter. The counter wraps.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- state_in  input  2  sequencer state code, synchronous to clk.
- err_clr  input  1  single-cycle pulse that clears the sticky error.
- dur_s1  output  DUR_W  cycles spent in S1 during the last completed round.
- dur_s2  output  DUR_W  cycles spent in S2 during the last completed round.
- dur_vld  output  1  one-cycle pulse; dur_s1, dur_s2 and round_cnt are updated in this same cycle.
- round_cnt  output  RND_W  number of completed legal rounds.
- err  output  1  sticky error flag.
- err_info  output  4  {previous state, offending state} captured at the first error since the last clear.

Behaviour:
- Reset (async, rst_n=0): all outputs are 0. Internal state is also cleared: st_r=IDLE, run_cnt=0, s1_cap=0, round_ok=0.
- st_r is state_in registered every cycle. A transition is a cycle where state_in != st_r.
- run_cnt:
  - On a transition, run_cnt <= 1.
  - Otherwise run_cnt <= run_cnt+1, saturating at 2^DUR_W-1.
  - Result: a state sampled on N consecutive edges reads run_cnt=N at the edge that samples the next state.
- Legal transitions are IDLE->S1, S1->S2 and S2->IDLE. Everything else is an error, including:
  - IDLE->S2, S1->IDLE, S2->S1;
  - any transition into or out of 2'b11;
  - 2'b11 sampled while holding, which raises an error every cycle it persists.
- IDLE->S1: round_ok <= 1.
- S1->S2: s1_cap <= run_cnt (already saturated if applicable).
- S2->IDLE with round_ok=1, all in the following cycle:
  - dur_s1 <= s1_cap, dur_s2 <= run_cnt;
  - round_cnt <= round_cnt+1, wrapping from 2^RND_W-1 to 0;
  - dur_vld = 1 for exactly one cycle;
  - round_ok <= 0.
- S2->IDLE with round_ok=0: no update and no dur_vld. This covers a round whose IDLE->S1 was never seen.
- Error cycle:
  - round_ok <= 0 (the round is aborted and no dur_vld for it).
  - err <= 1.
  - If err was 0, err_info <= {st_r, state_in}. Later errors do not overwrite err_info until a clear.
- err_clr:
  - Clears err and err_info in the next cycle.
  - If an error occurs in the same cycle as err_clr, the set wins: err stays 1 and err_info captures the new error.
- Outputs hold their values between updates. dur_s1, dur_s2 and round_cnt are never cleared except by reset.
- Latency: 1 cycle from the edge that samples IDLE after S2 to dur_vld high.
- First edge after reset: st_r=IDLE. If state_in=S1 at that edge, it is a legal IDLE->S1 (sequencer and monitor share reset).
- Reset mid-round: all state is discarded and no dur_vld is emitted for the partial round.

Test Plan:
- Nominal round: IDLE 3 cycles, S1 10 cycles, S2 14 cycles, then IDLE -> one dur_vld pulse 1 cycle after IDLE is sampled; dur_s1=10, dur_s2=14, round_cnt=1, err=0.
- Back-to-back: three rounds with S1/S2 lengths (1,1), (5,7), (2,300) -> three dur_vld pulses with exactly those values; round_cnt=3. A 1-cycle state measures 1.
- Saturation with DUR_W=4: S1 held 20 cycles, S2 held 3 cycles -> dur_s1=15, dur_s2=3, dur_vld asserted.
- Illegal transition: IDLE->S1(4)->IDLE->S1(2)->S2(2)->IDLE -> err=1, err_info=4'b0100. The first round gives no dur_vld; the second round reports dur_s1=2, dur_s2=2.
- Illegal code plus clear: state_in=2'b11 for 2 cycles, then err_clr pulsed on a clean cycle -> err_info=4'b0011, err=0 the cycle after err_clr. Repeat with err_clr coincident with an S2->S1 transition -> err stays 1, err_info=4'b1001.
- Reset mid-round and wrap: assert rst_n=0 during S2 -> all outputs 0 immediately and no dur_vld afterwards. With RND_W=2, run 5 rounds -> round_cnt reads 1,2,3,0,1.
